// File: rtl/aes_pkg.sv
// Shared AES round-stage types and GF(2^8) helpers.
// inv_shift_rows() exists only when MIXCOL_INV_EN is defined.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mcs_fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Byte k of the state sits at [127-8k -: 8]; s[r][c] is byte 4c+r.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t res;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return res;
    endfunction

`ifdef MIXCOL_INV_EN
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t res;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return res;
    endfunction
`endif

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumn of one 32-bit column (a0 in the top byte).
// MIXCOL_INV_EN adds an inv select for InvMixColumns.
module mix_column_unit
    import aes_pkg::*;
(
`ifdef MIXCOL_INV_EN
    input  logic     inv,
`endif
    input  aes_col_t column,
    output aes_col_t mixed
);

    logic [7:0] a0, a1, a2, a3;
    aes_col_t   fwd;

    assign a0 = column[31:24];
    assign a1 = column[23:16];
    assign a2 = column[15:8];
    assign a3 = column[7:0];

    assign fwd[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign fwd[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign fwd[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign fwd[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

`ifdef MIXCOL_INV_EN
    aes_col_t rev;

    assign rev[31:24] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign rev[23:16] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign rev[15:8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign rev[7:0]   = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);

    assign mixed = inv ? rev : fwd;
`else
    assign mixed = fwd;
`endif

endmodule

// File: rtl/mix_columns_stage.sv
// ShiftRows on accept, then MixColumns COLS_PER_CYCLE columns per cycle in place.
// MIXCOL_INV_EN adds the inv port selecting the inverse transforms.
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   CALC  | mixing columns, col_cnt selects the current group
//   DONE  | out_state valid, held until out_ready
module mix_columns_stage
    import aes_pkg::*;
#(
    parameter integer COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last_round,
`ifdef MIXCOL_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NCYC = (COLS_PER_CYCLE == 4) ? 1 : (COLS_PER_CYCLE == 2) ? 2 : 4;

    if (COLS_PER_CYCLE !== 1 && COLS_PER_CYCLE !== 2 && COLS_PER_CYCLE !== 4) begin : g_bad_cols
        $error("mix_columns_stage: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mcs_fsm_t   fsm, fsm_nxt;
    logic [1:0] col_cnt;
    aes_state_t st, st_mixed, st_entry;
    logic       last;

    logic [COLS_PER_CYCLE-1:0][1:0]  sel;
    logic [COLS_PER_CYCLE-1:0][31:0] mixed_cols;

`ifdef MIXCOL_INV_EN
    logic inv_q;
    assign st_entry = inv ? inv_shift_rows(in_state) : shift_rows(in_state);
`else
    assign st_entry = shift_rows(in_state);
`endif

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
        aes_col_t picked;
        assign sel[j]  = 2'(int'(col_cnt) * COLS_PER_CYCLE + j);
        assign picked  = st[32*(3-int'(sel[j])) +: 32];
        mix_column_unit u_mix (
`ifdef MIXCOL_INV_EN
            .inv    (inv_q),
`endif
            .column (picked),
            .mixed  (mixed_cols[j])
        );
    end

    always_comb begin
        st_mixed = st;
        for (int j = 0; j < COLS_PER_CYCLE; j++)
            st_mixed[32*(3-int'(sel[j])) +: 32] = mixed_cols[j];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) fsm <= ST_IDLE;
        else        fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            ST_IDLE: if (in_valid)                   fsm_nxt = ST_CALC;
            ST_CALC: if (col_cnt == 2'(NCYC - 1))    fsm_nxt = ST_DONE;
            ST_DONE: if (out_ready)                  fsm_nxt = ST_IDLE;
            default:                                 fsm_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (fsm == ST_IDLE);
        out_valid = (fsm == ST_DONE);
        busy      = (fsm != ST_IDLE);
    end

    // Final rounds still spend NCYC cycles in CALC so latency never depends on round type.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st      <= '0;
            col_cnt <= 2'd0;
            last    <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            case (fsm)
                ST_IDLE: if (in_valid) begin
                    st      <= st_entry;
                    last    <= in_last_round;
                    col_cnt <= 2'd0;
`ifdef MIXCOL_INV_EN
                    inv_q   <= inv;
`endif
                end
                ST_CALC: begin
                    if (!last) st <= st_mixed;
                    col_cnt <= col_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_state = st;

endmodule

// File: tb/tb_mix_columns_stage.sv
// Directed bench for mix_columns_stage: vector table plus backpressure and reset sequences.
// Inverse vectors are added when MIXCOL_INV_EN is defined.
module tb_mix_columns_stage;

    localparam integer COLS = 1;
    localparam int     NCYC = 4 / COLS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         in_last_round = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         busy;
`ifdef MIXCOL_INV_EN
    logic         inv = 1'b0;
`endif

    always #5 clk = ~clk;

    mix_columns_stage #(.COLS_PER_CYCLE(COLS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_state      (in_state),
        .in_last_round (in_last_round),
`ifdef MIXCOL_INV_EN
        .inv           (inv),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_state     (out_state),
        .busy          (busy)
    );

    typedef struct {
        logic [127:0] st;
        logic         last;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] R1_IN   = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] R1_OUT  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] R1_SR   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] C0_IN   = 128'hdb000000_00130000_00005300_00000045;
    localparam logic [127:0] C0_OUT  = 128'h8e4da1bc_00000000_00000000_00000000;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_state      = v.st;
        in_last_round = v.last;
`ifdef MIXCOL_INV_EN
        inv           = v.inv;
`endif
    endtask

    // Wait up to a bounded number of edges for out_valid; returns edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < NCYC + 8) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_block(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        drive(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, 128'(busy), 128'(1));
        wait_valid(n);
        check({tag, "_latency"}, 128'(n), 128'(NCYC));
        check({tag, "_data"}, out_state, v.exp);
        check({tag, "_ready_in_done"}, 128'(in_ready), 128'(0));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_after"}, 128'({out_valid, busy}), 128'(0));
    endtask

    initial begin
        vec_t v, vb;
        int   n;
        int   seen;

        vecs.push_back('{R1_IN, 1'b0, 1'b0, R1_OUT});
        vecs.push_back('{R1_IN, 1'b1, 1'b0, R1_SR});
        vecs.push_back('{C0_IN, 1'b0, 1'b0, C0_OUT});
        vecs.push_back('{128'h00000045_db000000_00130000_00005300, 1'b0, 1'b0,
                         128'h00000000_8e4da1bc_00000000_00000000});
        vecs.push_back('{128'h00005300_00000045_db000000_00130000, 1'b0, 1'b0,
                         128'h00000000_00000000_8e4da1bc_00000000});
        vecs.push_back('{128'h00130000_00005300_00000045_db000000, 1'b0, 1'b0,
                         128'h00000000_00000000_00000000_8e4da1bc});
        vecs.push_back('{128'h0, 1'b0, 1'b0, 128'h0});
        vecs.push_back('{{128{1'b1}}, 1'b0, 1'b0, {128{1'b1}}});
        vecs.push_back('{C0_IN, 1'b1, 1'b0, 128'hdb135345_00000000_00000000_00000000});
`ifdef MIXCOL_INV_EN
        vecs.push_back('{128'h8e000000_000000bc_0000a100_004d0000, 1'b0, 1'b1,
                         128'hdb135345_00000000_00000000_00000000});
        vecs.push_back('{128'h004d0000_8e000000_000000bc_0000a100, 1'b0, 1'b1,
                         128'h00000000_db135345_00000000_00000000});
        vecs.push_back('{128'h0000a100_004d0000_8e000000_000000bc, 1'b0, 1'b1,
                         128'h00000000_00000000_db135345_00000000});
        vecs.push_back('{128'h000000bc_0000a100_004d0000_8e000000, 1'b0, 1'b1,
                         128'h00000000_00000000_00000000_db135345});
        vecs.push_back('{R1_IN, 1'b1, 1'b1, 128'hd4415df1_e02752e5_b8bf1130_1eb498ae});
        vecs.push_back('{128'h04cbd34c_e0f826e5_4806819a_2866197a, 1'b0, 1'b1, R1_SR});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        check("reset_state", out_state, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_block(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: held DONE ignores a waiting upstream block
        v  = vecs[0];
        vb = vecs[2];
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_latency", 128'(n), 128'(NCYC));
        @(negedge clk);
        drive(vb);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", k), {out_state, 1'b0},
                  {v.exp, 1'b0});
            check($sformatf("bp_flags%0d", k), 128'({out_valid, in_ready}), 128'(2'b10));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_return_idle", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accept_next", 128'(busy), 128'(1));
        wait_valid(n);
        check("bp_next_latency", 128'(n), 128'(NCYC));
        check("bp_next_data", out_state, vb.exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during CALC, then a clean block
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (NCYC >= 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_calc_flags", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        check("rst_calc_state", out_state, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < NCYC + 3; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("rst_no_output", 128'(seen), 128'(0));
        run_block(vecs[0], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
